maint_scheduler: RTL and testbench
==================================

# maint_scheduler

Sequencing controller for the machine-maintenance datapath: counts operating cycles against a programmable service interval and raises a due flag when the interval expires. It enforces a grace window, locks the machine out if service is not started in time, and times a minimum service duration. It counts completed services and drives the 8-bit status message shown to the operator. It sits between the operator inputs (run, maintenance request/done) and the message display.

## Interface
- GRACE, default 16: clocks allowed in DUE before lockout (≥1).
- SVC_MIN, default 4: minimum clocks in SERVICE before `maint_done` is honoured (≥1).
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- run  in  1  machine operating this cycle; cycle-count enable.
- maint_req  in  1  operator starts maintenance (level, sampled each edge).
- maint_done  in  1  operator finishes maintenance.
- thresh  in  8  service interval in run-cycles; 0 disables scheduling.
- due  out  1  high in DUE.
- locked  out  1  high in LOCKED.
- svc_count  out  8  completed services, saturating at 255.
- msj_f  out  8  status message.

## Operation
- States: RUN, DUE, SERVICE, LOCKED. Reset state RUN.
- Internal registers: cyc_cnt[7:0], grace_cnt, svc_tmr, thr_q[7:0], svc_count.
- thr_q loads `thresh` on every edge with rst=1 and on every SERVICE→RUN exit; it is held otherwise.
- RUN:
  - If maint_req=1: go to SERVICE. This takes priority over all other RUN transitions.
  - Else if run=1 and thr_q≠0 and cyc_cnt==thr_q−1: set cyc_cnt←thr_q and go to DUE.
  - Else if run=1: cyc_cnt increments.
  - With thr_q=0, cyc_cnt saturates at 255 and DUE is never entered.
- DUE:
  - `run` is ignored; cyc_cnt holds.
  - grace_cnt increments every clock.
  - If maint_req=1: go to SERVICE (priority).
  - Else if grace_cnt==GRACE−1: go to LOCKED.
- LOCKED:
  - Absorbing state; only maint_req=1 leaves it, to SERVICE.
  - run and maint_done are ignored.
- SERVICE:
  - svc_tmr is cleared on entry and increments every clock, saturating.
  - If maint_done=1 and svc_tmr≥SVC_MIN: go to RUN, clear cyc_cnt and grace_cnt, svc_count+1 (saturating), reload thr_q.
  - maint_done=1 with svc_tmr<SVC_MIN is ignored; no latching.
  - maint_req is ignored.
- grace_cnt clears on every entry to DUE.
- msj_f by state:
  - RUN: svc_count.
  - DUE: 8'hF0.
  - SERVICE: 8'h5A.
  - LOCKED: 8'hFF.
- Reset values: state RUN, cyc_cnt 0, grace_cnt 0, svc_tmr 0, svc_count 0, due 0, locked 0, msj_f 8'h00.

## Timing
- All state and counters update on the rising edge of clk.
- due, locked and msj_f decode directly from the state register and svc_count. They change in the cycle after the causing edge, with no extra latency.
- thresh=N, N≥1, run held high from the first post-reset edge: due rises after edge N.
- From DUE entry with no maint_req: locked rises after GRACE further edges.
- SERVICE entry at edge E: the earliest accepted maint_done is sampled at edge E+SVC_MIN+1. Minimum dwell is therefore SVC_MIN+1 cycles.
- svc_count and msj_f show the new count in the first RUN cycle.
- rst=1 at any edge, in any state, overrides all inputs. The next cycle shows reset values; thr_q=thresh.
- A change of `thresh` outside reset or service exit has no effect until the next reload.

## Structure
- maint_pkg holds:
  - state enum typedef (2-bit).
  - message constants MSG_DUE=8'hF0, MSG_SVC=8'h5A, MSG_LOCK=8'hFF.
  - default GRACE and SVC_MIN localparams.
- One sub-module, maint_sat_counter: parameterised width, with clear, enable and saturate. It is instanced for cyc_cnt, grace_cnt, svc_tmr and svc_count.
- FSM next-state logic is a single always_comb; all registers sit in always_ff with synchronous rst.

## Test plan
- thresh=3, run=1 continuously after reset: due=0 after edges 1–2, due=1 and msj_f=8'hF0 after edge 3; run pulses while in DUE leave cyc_cnt at 3.
- GRACE=16, enter DUE, no maint_req: locked=1 and msj_f=8'hFF after edge 16 in DUE; toggling run and maint_done has no effect; maint_req=1 → SERVICE, msj_f=8'h5A.
- SVC_MIN=4, in SERVICE assert maint_done at svc_tmr=2 → stays SERVICE; assert at svc_tmr=4 → RUN, svc_count=1, msj_f=8'h01.
- Simultaneous maint_req=1 on the edge cyc_cnt would reach thr_q → SERVICE, due never asserts; simultaneous maint_req and grace expiry → SERVICE, locked stays 0.
- thresh=0: 300 run cycles → never DUE, cyc_cnt saturates at 255; complete 256 services → svc_count holds 255.
- rst=1 for one edge while in LOCKED with thresh=5 → state RUN, locked=0, msj_f=8'h00, svc_count=0; due then rises after 5 run edges.

Source files
------------

// File: rtl/maint_scheduler_pkg.sv
// Shared types and constants for the maintenance scheduler.
// Holds the FSM state encoding, the operator message codes, the default
// GRACE / SVC_MIN values and the state-to-message decode helper.
package maint_pkg;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_DUE  = 2'd1,
      ST_SVC  = 2'd2,
      ST_LOCK = 2'd3
   } state_t;

   localparam logic [7:0] MSG_DUE  = 8'hF0;
   localparam logic [7:0] MSG_SVC  = 8'h5A;
   localparam logic [7:0] MSG_LOCK = 8'hFF;

   localparam int unsigned GRACE_DEFAULT   = 16;
   localparam int unsigned SVC_MIN_DEFAULT = 4;

   // Operator message for a given state; RUN shows the service count.
   function automatic logic [7:0] state_msg(input state_t st, input logic [7:0] cnt);
      logic [7:0] msg;
      case (st)
         ST_RUN:  msg = cnt;
         ST_DUE:  msg = MSG_DUE;
         ST_SVC:  msg = MSG_SVC;
         ST_LOCK: msg = MSG_LOCK;
         default: msg = cnt;
      endcase
      return msg;
   endfunction

endpackage

// File: rtl/maint_scheduler_if.sv
// Operator/display bundle of the maintenance scheduler.
// master: operator side (drives run, maint_req, maint_done, thresh).
// slave : scheduler side (drives due, locked, svc_count, msj_f).
interface maint_scheduler_if;

   logic       run;
   logic       maint_req;
   logic       maint_done;
   logic [7:0] thresh;
   logic       due;
   logic       locked;
   logic [7:0] svc_count;
   logic [7:0] msj_f;

   modport master (
      output run, maint_req, maint_done, thresh,
      input  due, locked, svc_count, msj_f
   );

   modport slave (
      input  run, maint_req, maint_done, thresh,
      output due, locked, svc_count, msj_f
   );

endinterface

// File: rtl/maint_sat_counter.sv
// Saturating up-counter with synchronous clear and enable.
// Ports: clk, rst (sync, active-high), clr (priority over en), en, q.
module maint_sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] q
);

   localparam logic [W-1:0] MAX = {W{1'b1}};

   // Count up, hold at all-ones.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= '0;
      end else if (en && (q != MAX)) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/maint_scheduler.sv
// Maintenance sequencing controller.
// Counts run cycles against a latched service interval, flags DUE, locks the
// machine out when the grace window expires, enforces a minimum service time
// and counts completed services.
// Ports: clk, rst (sync, active-high), bus (maint_scheduler_if.slave):
//   run, maint_req, maint_done, thresh in; due, locked, svc_count, msj_f out.
module maint_scheduler
   import maint_pkg::*;
#(
   parameter int unsigned GRACE   = GRACE_DEFAULT,
   parameter int unsigned SVC_MIN = SVC_MIN_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   maint_scheduler_if.slave bus
);

   localparam int unsigned GRACE_W = (GRACE > 1) ? $clog2(GRACE) : 1;
   localparam int unsigned TMR_W   = $clog2(SVC_MIN + 1);

   state_t              state_q, state_d;
   logic [7:0]          thr_q;
   logic [7:0]          cyc_cnt;
   logic [GRACE_W-1:0]  grace_cnt;
   logic [TMR_W-1:0]    svc_tmr;
   logic [7:0]          svc_count;
   logic [7:0]          svc_count_nxt_c;

   logic cyc_en, cyc_clr;
   logic grace_en, grace_clr;
   logic tmr_en, tmr_clr;
   logic svc_exit;

   // Next state and counter controls.
   always_comb begin
      state_d   = state_q;
      cyc_en    = 1'b0;
      cyc_clr   = 1'b0;
      grace_en  = 1'b0;
      grace_clr = 1'b0;
      tmr_en    = 1'b0;
      tmr_clr   = 1'b0;
      svc_exit  = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (bus.maint_req) begin
               state_d = ST_SVC;
               tmr_clr = 1'b1;
            end else if (bus.run) begin
               // The increment lands cyc_cnt exactly on thr_q when DUE is entered.
               cyc_en = 1'b1;
               if ((thr_q != 8'd0) && (cyc_cnt == (thr_q - 8'd1))) begin
                  state_d   = ST_DUE;
                  grace_clr = 1'b1;
               end
            end
         end
         ST_DUE: begin
            grace_en = 1'b1;
            if (bus.maint_req) begin
               state_d = ST_SVC;
               tmr_clr = 1'b1;
            end else if (grace_cnt == GRACE_W'(GRACE - 1)) begin
               state_d = ST_LOCK;
            end
         end
         ST_LOCK: begin
            if (bus.maint_req) begin
               state_d = ST_SVC;
               tmr_clr = 1'b1;
            end
         end
         ST_SVC: begin
            tmr_en = 1'b1;
            if (bus.maint_done && (svc_tmr >= TMR_W'(SVC_MIN))) begin
               state_d   = ST_RUN;
               cyc_clr   = 1'b1;
               grace_clr = 1'b1;
               svc_exit  = 1'b1;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Service interval latch: reloaded only in reset and on service exit.
   always_ff @(posedge clk) begin
      if (rst || svc_exit) begin
         thr_q <= bus.thresh;
      end
   end

   maint_sat_counter #(.W(8)) u_cyc (
      .clk(clk), .rst(rst), .clr(cyc_clr), .en(cyc_en), .q(cyc_cnt)
   );

   maint_sat_counter #(.W(GRACE_W)) u_grace (
      .clk(clk), .rst(rst), .clr(grace_clr), .en(grace_en), .q(grace_cnt)
   );

   maint_sat_counter #(.W(TMR_W)) u_tmr (
      .clk(clk), .rst(rst), .clr(tmr_clr), .en(tmr_en), .q(svc_tmr)
   );

   maint_sat_counter #(.W(8)) u_svc (
      .clk(clk), .rst(rst), .clr(1'b0), .en(svc_exit), .q(svc_count)
   );

   // Count value after this edge, so the RUN message shows it immediately.
   assign svc_count_nxt_c = (svc_exit && (svc_count != 8'hFF)) ? svc_count + 8'd1 : svc_count;

   // Status outputs registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.due    <= 1'b0;
         bus.locked <= 1'b0;
         bus.msj_f  <= 8'h00;
      end else begin
         bus.due    <= (state_d == ST_DUE);
         bus.locked <= (state_d == ST_LOCK);
         bus.msj_f  <= state_msg(state_d, svc_count_nxt_c);
      end
   end

   assign bus.svc_count = svc_count;

endmodule

// File: tb/tb_maint_scheduler.sv
// Randomised and directed bench for maint_scheduler against a behavioural model.
module tb_maint_scheduler;

   localparam int unsigned GRACE   = 16;
   localparam int unsigned SVC_MIN = 4;

   localparam int M_RUN = 0, M_DUE = 1, M_SVC = 2, M_LOCK = 3;

   logic clk;
   logic rst;
   maint_scheduler_if bus();

   maint_scheduler #(.GRACE(GRACE), .SVC_MIN(SVC_MIN)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: mode plus plain integer counters.
   int          m_st = M_RUN;
   int unsigned m_cyc = 0, m_grace = 0, m_tmr = 0, m_svc = 0, m_thr = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model(input logic r, input logic rn, input logic rq, input logic dn,
                        input logic [7:0] th);
      if (r) begin
         m_st = M_RUN; m_cyc = 0; m_grace = 0; m_tmr = 0; m_svc = 0; m_thr = th;
      end else begin
         case (m_st)
            M_RUN: begin
               if (rq) begin
                  m_st = M_SVC; m_tmr = 0;
               end else if (rn) begin
                  if (m_thr != 0 && m_cyc + 1 == m_thr) begin
                     m_cyc = m_thr; m_st = M_DUE; m_grace = 0;
                  end else if (m_cyc < 255) begin
                     m_cyc++;
                  end
               end
            end
            M_DUE: begin
               if (rq) begin
                  m_st = M_SVC; m_tmr = 0;
               end else if (m_grace == GRACE - 1) begin
                  m_st = M_LOCK;
               end else begin
                  m_grace++;
               end
            end
            M_LOCK: begin
               if (rq) begin
                  m_st = M_SVC; m_tmr = 0;
               end
            end
            default: begin
               if (dn && m_tmr >= SVC_MIN) begin
                  m_st = M_RUN; m_cyc = 0; m_grace = 0; m_thr = th;
                  if (m_svc < 255) m_svc++;
               end else begin
                  m_tmr++;
               end
            end
         endcase
      end
   endtask

   function automatic logic [7:0] exp_msg();
      case (m_st)
         M_RUN:   return 8'(m_svc);
         M_DUE:   return 8'hF0;
         M_SVC:   return 8'h5A;
         default: return 8'hFF;
      endcase
   endfunction

   // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
   task automatic step(input logic r, input logic rn, input logic rq, input logic dn,
                       input logic [7:0] th);
      rst = r; bus.run = rn; bus.maint_req = rq; bus.maint_done = dn; bus.thresh = th;
      @(posedge clk);
      model(r, rn, rq, dn, th);
      #1;
      check("due", 32'(bus.due), 32'(m_st == M_DUE));
      check("locked", 32'(bus.locked), 32'(m_st == M_LOCK));
      check("msj_f", 32'(bus.msj_f), 32'(exp_msg()));
      check("svc_count", 32'(bus.svc_count), m_svc);
      check("cyc_cnt", 32'(dut.cyc_cnt), m_cyc);
   endtask

   task automatic finish_service(input logic [7:0] th);
      for (int k = 0; k < 12 && m_st == M_SVC; k++) step(1'b0, 1'b0, 1'b0, 1'b1, th);
   endtask

   initial begin
      rst = 1'b1; bus.run = 1'b0; bus.maint_req = 1'b0; bus.maint_done = 1'b0; bus.thresh = 8'd3;

      // Reset, then thresh=3 with run held high.
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
      check("rst_msj", 32'(bus.msj_f), 32'h00);
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
      check("due_e2", 32'(bus.due), 32'h0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
      check("due_e3", 32'(bus.due), 32'h1);
      check("due_msj", 32'(bus.msj_f), 32'hF0);

      // Grace window with run pulses, then lockout.
      for (int i = 0; i < 15; i++) step(1'b0, 1'(i % 2), 1'b0, 1'b0, 8'd9);
      check("grace_15", 32'(bus.locked), 32'h0);
      check("due_cyc", 32'(dut.cyc_cnt), 32'd3);
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'd9);
      check("lock_16", 32'(bus.locked), 32'h1);
      check("lock_msj", 32'(bus.msj_f), 32'hFF);
      for (int i = 0; i < 6; i++) step(1'b0, 1'(i % 2), 1'b0, 1'(i / 2 % 2), 8'd9);

      // Service: early done ignored, later done honoured.
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'd3);
      check("svc_msj", 32'(bus.msj_f), 32'h5A);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'd3);
      check("early_done", 32'(bus.msj_f), 32'h5A);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'd3);
      check("svc_done_cnt", 32'(bus.svc_count), 32'd1);
      check("svc_done_msj", 32'(bus.msj_f), 32'h01);

      // Request on the edge that would make DUE.
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'd3);
      check("req_vs_due", 32'(bus.due), 32'h0);
      finish_service(8'd3);

      // Request on the grace-expiry edge.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
      for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'd3);
      check("req_vs_lock", 32'(bus.locked), 32'h0);
      finish_service(8'd3);

      // Random traffic with a moving thresh input.
      for (int i = 0; i < 4000; i++) begin
         step(1'($urandom_range(0, 299) == 0),
              1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 15) == 0),
              1'($urandom_range(0, 1)),
              8'($urandom_range(0, 12)));
      end

      // thresh=0 disables scheduling; cyc_cnt saturates.
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
      check("sat_cyc", 32'(dut.cyc_cnt), 32'd255);
      check("sat_due", 32'(bus.due), 32'h0);

      // 256 services saturate svc_count.
      for (int s = 0; s < 256; s++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
         finish_service(8'd0);
      end
      check("svc_sat", 32'(bus.svc_count), 32'd255);
      check("svc_sat_msj", 32'(bus.msj_f), 32'hFF);

      // Reset out of LOCKED.
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
      for (int i = 0; i < 2 + GRACE; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
      check("pre_rst_lock", 32'(bus.locked), 32'h1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
      check("rst_lock", 32'(bus.locked), 32'h0);
      check("rst_msj2", 32'(bus.msj_f), 32'h00);
      check("rst_svc", 32'(bus.svc_count), 32'h0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'd7);
      check("thr5_e4", 32'(bus.due), 32'h0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'd7);
      check("thr5_e5", 32'(bus.due), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
